// File: rtl/sd_cmd_controller_if.sv
// rtl/sd_cmd_controller_if.sv - host-side command/response bus of the SD CMD-line controller
//
// Ports (master = host, slave = controller):
//   cmd_start    host -> ctrl  one-cycle command request
//   cmd_index    host -> ctrl  6-bit command index
//   cmd_arg      host -> ctrl  32-bit command argument
//   resp_type    host -> ctrl  00 none, 01 48-bit+CRC, 10 136-bit, 11 48-bit no CRC
//   busy         ctrl -> host  command in progress
//   done         ctrl -> host  one-cycle completion pulse
//   resp         ctrl -> host  captured response (128 bits)
//   timeout_err  ctrl -> host  no response start bit in time
//   crc_err      ctrl -> host  response CRC7 mismatch
interface sd_cmd_controller_if;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         busy;
  logic         done;
  logic [127:0] resp;
  logic         timeout_err;
  logic         crc_err;

  modport master (
    output cmd_start, cmd_index, cmd_arg, resp_type,
    input  busy, done, resp, timeout_err, crc_err
  );

  modport slave (
    input  cmd_start, cmd_index, cmd_arg, resp_type,
    output busy, done, resp, timeout_err, crc_err
  );
endinterface

// File: rtl/sd_cmd_controller.sv
// rtl/sd_cmd_controller.sv - SD CMD-line controller: 48-bit command out, optional response in
//
// Ports:
//   clock        single rising-edge clock
//   reset        synchronous active-high reset
//   host         sd_cmd_controller_if.slave command/response bus
//   cmd_pin_in   CMD line sampled from the card
//   cmd_pin_out  CMD line driven to the card (idles high)
//   cmd_oe       CMD output enable, high only while the command frame is sent
// Parameter TIMEOUT_CYCLES: wait cycles allowed for the response start bit.
// Macro RESP_CRC_CHECK_EN: when defined, type-01 responses get a CRC7 check
// driving crc_err; otherwise crc_err is tied low.
module sd_cmd_controller #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  sd_cmd_controller_if.slave   host,
  input  logic                 cmd_pin_in,
  output logic                 cmd_pin_out,
  output logic                 cmd_oe
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, DONE} state_t;
  state_t state, state_next;

  logic [39:0]   tx_shift;     // start, transmit, index, arg; MSB goes out first
  logic [6:0]    tx_crc;       // accumulates over the first 40 bits, then shifts out
  logic [7:0]    bit_cnt;
  logic [TW-1:0] wait_cnt;
  logic [1:0]    resp_type_q;
  logic [126:0]  rx_shift;     // older bits fall off the top, which drops the 8 leading bits of a 136-bit reply
  logic [127:0]  resp_q;
  logic          timeout_q;

  logic accept, send_last, start_seen, wait_expired, recv_last;

  // One serial step of CRC7 with G(x) = x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    return {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & 7'h09);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    send_last    = 1'b0;
    start_seen   = 1'b0;
    wait_expired = 1'b0;
    recv_last    = 1'b0;
    cmd_oe       = 1'b0;
    cmd_pin_out  = 1'b1;
    case (state)
      IDLE: begin
        if (host.cmd_start) begin
          accept     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        cmd_oe = 1'b1;
        if (bit_cnt < 8'd40)      cmd_pin_out = tx_shift[39];
        else if (bit_cnt < 8'd47) cmd_pin_out = tx_crc[6];
        else                      cmd_pin_out = 1'b1;
        if (bit_cnt == 8'd47) begin
          send_last  = 1'b1;
          state_next = (resp_type_q == 2'b00) ? DONE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (!cmd_pin_in) begin
          start_seen = 1'b1;
          state_next = RECV;
        end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          wait_expired = 1'b1;
          state_next   = DONE;
        end
      end
      RECV: begin
        // The start bit was taken in WAIT_RESP, so 47 or 135 bits remain.
        if (bit_cnt == ((resp_type_q == 2'b10) ? 8'd134 : 8'd46)) begin
          recv_last  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_shift    <= '0;
      tx_crc      <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      resp_type_q <= '0;
      rx_shift    <= '0;
      resp_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_shift    <= {2'b01, host.cmd_index, host.cmd_arg};
            tx_crc      <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            resp_type_q <= host.resp_type;
            timeout_q   <= 1'b0;
          end
        end
        SEND: begin
          bit_cnt <= send_last ? 8'd0 : bit_cnt + 8'd1;
          if (bit_cnt < 8'd40) begin
            tx_crc   <= crc7_step(tx_crc, tx_shift[39]);
            tx_shift <= {tx_shift[38:0], 1'b0};
          end else begin
            tx_crc   <= {tx_crc[5:0], 1'b0};
          end
        end
        WAIT_RESP: begin
          wait_cnt <= (start_seen || wait_expired) ? '0 : wait_cnt + TW'(1);
          if (start_seen) begin
            rx_shift <= '0;         // the start bit is a zero, already in place
            bit_cnt  <= '0;
          end
          if (wait_expired) timeout_q <= 1'b1;
        end
        RECV: begin
          rx_shift <= {rx_shift[125:0], cmd_pin_in};
          bit_cnt  <= recv_last ? 8'd0 : bit_cnt + 8'd1;
          if (recv_last) resp_q <= {rx_shift, cmd_pin_in};
        end
        default: ;
      endcase
    end
  end

  assign host.busy        = (state != IDLE);
  assign host.done        = (state == DONE);
  assign host.resp        = resp_q;
  assign host.timeout_err = timeout_q;

`ifdef RESP_CRC_CHECK_EN
  logic [6:0] rx_crc;
  logic       crc_err_q;

  // Frame bits [47:8] are the start bit plus RECV counts 0..38; bits [7:1]
  // sit in rx_shift[6:0] when the end bit arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_crc    <= '0;
      crc_err_q <= 1'b0;
    end else begin
      if (accept) crc_err_q <= 1'b0;
      if (start_seen)
        rx_crc <= '0;
      else if (state == RECV && bit_cnt < 8'd39)
        rx_crc <= crc7_step(rx_crc, cmd_pin_in);
      if (recv_last && resp_type_q == 2'b01)
        crc_err_q <= (rx_crc != rx_shift[6:0]);
    end
  end

  assign host.crc_err = crc_err_q;
`else
  assign host.crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_controller.sv
// tb/tb_sd_cmd_controller.sv - directed and randomized bench for sd_cmd_controller
module tb_sd_cmd_controller;
  localparam int TO = 20;
`ifdef RESP_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic cmd_pin_in, cmd_pin_out, cmd_oe;

  sd_cmd_controller_if bus();

  sd_cmd_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .host        (bus),
    .cmd_pin_in  (cmd_pin_in),
    .cmd_pin_out (cmd_pin_out),
    .cmd_oe      (cmd_oe)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC7 as polynomial long division of data*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_of(input logic [39:0] d);
    logic [46:0] m;
    m = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m = m ^ (47'h89 << (i - 7));
    return m[6:0];
  endfunction

  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] d;
    d = {2'b01, idx, arg};
    return {d, crc7_of(d), 1'b1};
  endfunction

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] t);
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.resp_type = t;
    bus.cmd_start = 1'b1;
    @(negedge clock);
    bus.cmd_start = 1'b0;
    bus.cmd_index = ~idx;
    bus.cmd_arg   = ~arg;
    bus.resp_type = ~t;
  endtask

  task automatic send_phase(input int poke, output logic [47:0] f, output int oe_cnt);
    f = '0;
    oe_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      f = {f[46:0], cmd_pin_out};
      if (cmd_oe) oe_cnt++;
      bus.cmd_start = (i == poke);
      @(negedge clock);
    end
    bus.cmd_start = 1'b0;
  endtask

  task automatic respond(input int idle, input logic [135:0] bits, input int n, input int poke);
    for (int i = 0; i < idle; i++) begin
      cmd_pin_in = 1'b1;
      @(negedge clock);
    end
    for (int i = 0; i < n; i++) begin
      cmd_pin_in    = bits[n-1-i];
      bus.cmd_start = (i == poke);
      @(negedge clock);
    end
    cmd_pin_in    = 1'b1;
    bus.cmd_start = 1'b0;
  endtask

  task automatic finish_check(input string tag, input logic [127:0] exp_resp,
                              input logic exp_crc, input logic exp_to);
    check({tag, "_done"},    128'(bus.done),        128'(1'b1));
    check({tag, "_busy"},    128'(bus.busy),        128'(1'b1));
    check({tag, "_resp"},    bus.resp,              exp_resp);
    check({tag, "_crc_err"}, 128'(bus.crc_err),     128'(exp_crc));
    check({tag, "_timeout"}, 128'(bus.timeout_err), 128'(exp_to));
    @(negedge clock);
    check({tag, "_idle"},    128'({bus.done, bus.busy, cmd_oe}), 128'(3'b000));
    check({tag, "_hold"},    128'({bus.crc_err, bus.timeout_err}), 128'({exp_crc, exp_to}));
  endtask

  initial begin
    logic [47:0]  f, r48;
    logic [135:0] r136;
    logic [127:0] last_resp;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   t;
    logic         bad;
    int           oe_cnt, n, idle, dones;

    reset = 1'b1;
    cmd_pin_in = 1'b1;
    bus.cmd_start = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;
    bus.resp_type = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 128'({cmd_pin_out, cmd_oe, bus.busy, bus.done, bus.timeout_err, bus.crc_err}),
          128'(6'b100000));
    check("reset_resp", bus.resp, '0);
    reset = 1'b0;
    @(negedge clock);

    // CMD0, no response
    issue(6'd0, 32'd0, 2'b00);
    send_phase(-1, f, oe_cnt);
    check("cmd0_frame", 128'(f), 128'(48'h400000000095));
    check("cmd0_oe", 128'(oe_cnt), 128'(48));
    finish_check("cmd0", '0, 1'b0, 1'b0);

    // CMD8 with valid R7-style reply after 5 idle cycles
    issue(6'd8, 32'h000001AA, 2'b01);
    send_phase(-1, f, oe_cnt);
    check("cmd8_frame", 128'(f), 128'(48'h48000001AA87));
    r48 = {40'h08000001AA, crc7_of(40'h08000001AA), 1'b1};
    respond(5, 136'(r48), 48, -1);
    finish_check("cmd8", 128'(r48), 1'b0, 1'b0);
    last_resp = 128'(r48);

    // Same with a corrupted CRC bit
    issue(6'd8, 32'h000001AA, 2'b01);
    send_phase(-1, f, oe_cnt);
    respond(5, 136'(r48 ^ 48'h4), 48, -1);
    last_resp = 128'(r48 ^ 48'h4);
    finish_check("cmd8_badcrc", last_resp, CRC_ON, 1'b0);

    // No reply: timeout after TO full wait cycles, resp untouched
    issue(6'd17, $urandom, 2'b01);
    check("crc_err_cleared_on_accept", 128'(bus.crc_err), 128'(1'b0));
    send_phase(-1, f, oe_cnt);
    n = 1;
    while (!bus.done && n < TO + 10) begin
      @(negedge clock);
      n++;
    end
    check("timeout_latency", 128'(n), 128'(TO + 1));
    finish_check("timeout", last_resp, 1'b0, 1'b1);

    // Start bit in the last allowed wait cycle, type 11 with junk CRC field
    issue(6'd2, $urandom, 2'b11);
    check("timeout_cleared_on_accept", 128'(bus.timeout_err), 128'(1'b0));
    send_phase(-1, f, oe_cnt);
    r48 = {1'b0, 39'($urandom) ^ (39'($urandom) << 20), ~crc7_of(40'd0), 1'b1};
    respond(TO - 1, 136'(r48), 48, -1);
    last_resp = 128'(r48);
    finish_check("late_start", last_resp, 1'b0, 1'b0);

    // Randomized commands and replies, cmd_start poked while busy
    for (int k = 0; k < 10; k++) begin
      idx = 6'($urandom);
      arg = $urandom;
      t   = (k == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      issue(idx, arg, t);
      send_phase(int'($urandom_range(0, 47)), f, oe_cnt);
      check("rand_frame", 128'(f), 128'(frame_of(idx, arg)));
      check("rand_oe", 128'(oe_cnt), 128'(48));
      idle = $urandom_range(0, TO - 1);
      if (t == 2'b00) begin
        finish_check("rand_none", last_resp, 1'b0, 1'b0);
      end else if (t == 2'b10) begin
        for (int b = 0; b < 136; b++) r136[b] = 1'($urandom_range(0, 1));
        r136[135] = 1'b0;
        respond(idle, r136, 136, int'($urandom_range(0, 135)));
        last_resp = r136[127:0];
        finish_check("rand_r136", last_resp, 1'b0, 1'b0);
      end else begin
        for (int b = 8; b < 47; b++) r48[b] = 1'($urandom_range(0, 1));
        r48[47] = 1'b0;
        r48[0]  = 1'b1;
        r48[7:1] = (t == 2'b01) ? crc7_of(r48[47:8]) : 7'($urandom);
        bad = (t == 2'b01) && ($urandom_range(0, 1) == 1);
        if (bad) r48[7] = ~r48[7];
        respond(idle, 136'(r48), 48, int'($urandom_range(0, 47)));
        last_resp = 128'(r48);
        finish_check("rand_r48", last_resp, CRC_ON && bad, 1'b0);
      end
    end

    // Reset during SEND cycle 20 aborts without a done pulse
    issue(6'd5, 32'hDEADBEEF, 2'b01);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_state", 128'({cmd_pin_out, cmd_oe, bus.busy, bus.done}), 128'(4'b1000));
    check("abort_resp", bus.resp, '0);
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done) dones++;
      @(negedge clock);
    end
    check("abort_no_done", 128'(dones), 128'(0));
    issue(6'd0, 32'd0, 2'b00);
    send_phase(-1, f, oe_cnt);
    check("after_abort_frame", 128'(f), 128'(48'h400000000095));
    finish_check("after_abort", '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sd_cmd_controller.md
SD_CMD_CONTROLLER -- requirements
Module: sd_cmd_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: clock cycles allowed between the end of a transmitted command and the response start bit.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_start  input  1  one-cycle request to issue a command; sampled only in IDLE.
REQ-005 cmd_index  input  6  command index (00Eh[13:8]).
REQ-006 cmd_arg  input  32  command argument (008h).
REQ-007 resp_type  input  2  expected response: 00 none, 01 48-bit with CRC, 10 136-bit, 11 48-bit without CRC.
REQ-008 cmd_pin_in  input  1  CMD line sampled from card.
REQ-009 cmd_pin_out  output  1  CMD line driven to card.
REQ-010 cmd_oe  output  1  CMD output enable.
REQ-011 busy  output  1  command in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 resp  output  128  captured response.
REQ-014 timeout_err  output  1  no response start bit within TIMEOUT_CYCLES.
REQ-015 crc_err  output  1  response CRC7 mismatch.

Function
REQ-016 States: IDLE, SEND, WAIT_RESP, RECV, DONE; one CMD bit per clock, MSB first.
REQ-017 In IDLE, cmd_start=1 latches cmd_index, cmd_arg and resp_type, clears timeout_err and crc_err, and moves to SEND; cmd_start outside IDLE is ignored.
REQ-018 Frame is 48 bits: start 0, transmit 1, index[5:0], arg[31:0], CRC7[6:0], end 1.
REQ-019 CRC7 uses G(x)=x^7+x^3+1 over the first 40 frame bits, register initialised to zero.
REQ-020 SEND lasts exactly 48 cycles, frame bit 47 in the cycle after cmd_start, with cmd_oe=1 throughout; cmd_oe=0 and cmd_pin_out=1 in every other state.
REQ-021 After SEND: resp_type 00 goes to DONE; otherwise goes to WAIT_RESP.
REQ-022 WAIT_RESP samples cmd_pin_in each cycle.
  - 0 moves to RECV; this start bit counts as frame bit 0.
  - TIMEOUT_CYCLES cycles with no 0 sets timeout_err and moves to DONE.
REQ-023 RECV shifts in a further 47 bits (types 01/11) or 135 bits (type 10), then moves to DONE.
REQ-024 resp contents:
  - 48-bit: resp[47:0] holds the full frame; resp[127:48]=0.
  - 136-bit: resp holds frame bits [127:0], with the leading 8 bits discarded.
REQ-025 resp is updated only at the RECV-to-DONE transition and is held until the next accepted response; a timeout leaves it unchanged.
REQ-026 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-027 busy=1 from the cycle after cmd_start is accepted through DONE inclusive.
REQ-028 timeout_err and crc_err hold their value until the next accepted cmd_start or reset.
REQ-029 A back-to-back cmd_start in the cycle after DONE is accepted.

Reset
REQ-030 Reset values: state IDLE, cmd_pin_out=1, cmd_oe=0, busy=0, done=0, resp=0, timeout_err=0, crc_err=0, all counters 0.
REQ-031 Reset asserted mid-operation aborts the command; reset values appear at the next clock edge, with no done pulse.

Configuration
REQ-032 With RESP_CRC_CHECK_EN defined, for type 01 the controller computes CRC7 over received bits [47:8], compares it with bits [7:1], and sets crc_err on mismatch at DONE.
REQ-033 Without RESP_CRC_CHECK_EN, crc_err is constant 0 and no receive CRC logic is built.
REQ-034 Types 10 and 11 never set crc_err in either configuration.

Verification
REQ-035 CMD0 case: index 0, arg 0, type 00 -> cmd_pin_out carries 0x400000000095 over 48 cycles with cmd_oe=1, then done at cycle 49 and timeout_err=0.
REQ-036 CMD8 case: index 8, arg 0x000001AA, type 01 -> frame 0x48000001AA87; card replies 0x08000001AA followed by a valid CRC7 and end bit 1 after 5 idle cycles -> resp[47:0] equals that frame, crc_err=0, done pulse.
REQ-037 Same as REQ-036 but with one response CRC bit flipped -> crc_err=1 with RESP_CRC_CHECK_EN defined, 0 without it.
REQ-038 cmd_pin_in held at 1 with type 01 -> timeout_err=1 and done exactly TIMEOUT_CYCLES cycles after the last SEND cycle; resp is unchanged.
REQ-039 Reset pulsed at SEND cycle 20 -> next cycle shows cmd_oe=0 and busy=0, no done pulse; a subsequent cmd_start completes normally.
REQ-040 Type 10 with a 136-bit reply -> resp[127:0] equals transmitted bits [127:0]; cmd_start pulses while busy are ignored.
